// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the TDM 1:N demultiplexer.
// DEMUX_PARITY_EN: frames carry one extra even-parity beat after the lanes.
package tdm_demux_pkg;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam int DEF_NUM_CH = 8;
  localparam int DEF_DATA_W = 1;

  // Beats per frame for a given lane count (lanes, plus parity beat when enabled)
  function automatic int frame_len(input int n);
`ifdef DEMUX_PARITY_EN
    return n + 1;
`else
    return n;
`endif
  endfunction

  localparam int FRAME_LEN = frame_len(DEF_NUM_CH);

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-LEN slot counter: clear beats load-to-1, which beats count enable.
// o_wrap flags the enabled beat that takes the count from LEN-1 back to 0.
module tdm_slot_counter #(
  parameter int LEN = 8,
  parameter int W   = $clog2(LEN)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_load1,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);

  logic [W-1:0] r_cnt;

  assign o_cnt  = r_cnt;
  assign o_wrap = i_en && (r_cnt == W'(LEN - 1));

  // Slot register: clear / load-1 / count with wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_cnt <= '0;
    else if (i_clr)    r_cnt <= '0;
    else if (i_load1)  r_cnt <= W'(1);
    else if (i_en)     r_cnt <= o_wrap ? '0 : r_cnt + 1'b1;
  end

endmodule

// File: rtl/tdm_demux_1to8.sv
// TDM 1:N demultiplexer: steers serial beats into a shadow word by slot and
// publishes the whole word on y with a one-cycle frame_valid strobe.
// DEMUX_PARITY_EN: adds an even-parity beat per frame and the par_err output.
module tdm_demux_1to8
  import tdm_demux_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  parameter  int DATA_W = DEF_DATA_W,
  localparam int FL     = frame_len(NUM_CH),
  localparam int SLOT_W = $clog2(FL)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        din,
  input  logic                     din_valid,
  input  logic                     frame_start,
  output logic [NUM_CH*DATA_W-1:0] y,
  output logic                     frame_valid,
  output logic [SLOT_W-1:0]        slot,
  output logic                     sync_err
`ifdef DEMUX_PARITY_EN
  ,
  output logic                     par_err
`endif
);

  // Without parity the last lane goes straight from din to y, so it is not stored.
`ifdef DEMUX_PARITY_EN
  localparam int SH_N = NUM_CH;
`else
  localparam int SH_N = NUM_CH - 1;
`endif

  state_t                          r_state, w_state_nxt;
  logic [SH_N-1:0][DATA_W-1:0]     r_shadow;
  logic [NUM_CH-1:0][DATA_W-1:0]   w_word;
  logic w_ld1, w_clr, w_en, w_lane_wr, w_serr, w_wrap, w_par_ok;

  tdm_slot_counter #(.LEN(FL), .W(SLOT_W)) u_slot (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_en),
    .i_load1(w_ld1),
    .i_clr  (w_clr),
    .o_cnt  (slot),
    .o_wrap (w_wrap)
  );

  // Framing state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Framing decisions for the current beat
  always_comb begin
    w_state_nxt = r_state;
    w_ld1       = 1'b0;
    w_clr       = 1'b0;
    w_en        = 1'b0;
    w_lane_wr   = 1'b0;
    w_serr      = 1'b0;
    if (din_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (frame_start) begin
            w_ld1       = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (frame_start) begin
            // Start of a frame; mid-frame restart drops the partial frame
            w_ld1  = 1'b1;
            w_serr = (slot != '0);
          end else if (slot == '0) begin
            // Lost alignment: go back to hunting
            w_serr      = 1'b1;
            w_clr       = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_en      = 1'b1;
            w_lane_wr = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Slot -> lane write enables; lane 0 is written only by a frame-start beat
  for (genvar k = 0; k < SH_N; k++) begin : g_lane
    logic w_we;
    assign w_we = (k == 0) ? w_ld1 : (w_lane_wr && slot == SLOT_W'(k));
    // Per-lane shadow capture
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    r_shadow[k] <= '0;
      else if (w_we) r_shadow[k] <= din;
    end
  end

`ifdef DEMUX_PARITY_EN
  assign w_word   = r_shadow;
  assign w_par_ok = ~((^r_shadow) ^ (^din));
`else
  assign w_word   = {din, r_shadow};
  assign w_par_ok = 1'b1;
`endif

  // Publish register and one-cycle status strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y           <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
`ifdef DEMUX_PARITY_EN
      par_err     <= 1'b0;
`endif
    end else begin
      frame_valid <= w_wrap && w_par_ok;
      sync_err    <= w_serr;
`ifdef DEMUX_PARITY_EN
      par_err     <= w_wrap && !w_par_ok;
`endif
      if (w_wrap && w_par_ok) y <= w_word;
    end
  end

endmodule

// File: tb/tb_tdm_demux_1to8.sv
// Self-checking bench for tdm_demux_1to8 (NUM_CH=8, DATA_W=1): directed
// framing scenarios followed by random streams, checked against a frame model.
module tb_tdm_demux_1to8;
  import tdm_demux_pkg::*;

  localparam int N  = DEF_NUM_CH;
  localparam int FL = FRAME_LEN;
  localparam int SW = $clog2(FL);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          din = 1'b0;
  logic          din_valid = 1'b0;
  logic          frame_start = 1'b0;
  logic [N-1:0]  y;
  logic          frame_valid;
  logic [SW-1:0] slot;
  logic          sync_err;
`ifdef DEMUX_PARITY_EN
  logic          par_err;
`endif

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int fv_cyc[$];
  int se_seen;

  // Reference model state: frame bits collected so far, published word, strobes
  bit           m_run;
  int           m_slot;
  bit           m_bits[FL];
  logic [N-1:0] m_y;
  bit           m_fv, m_se, m_pe;

  tdm_demux_1to8 #(.NUM_CH(N), .DATA_W(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_start(frame_start),
    .y          (y),
    .frame_valid(frame_valid),
    .slot       (slot),
    .sync_err   (sync_err)
`ifdef DEMUX_PARITY_EN
    ,
    .par_err    (par_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_slot = 0; m_y = '0; m_fv = 0; m_se = 0; m_pe = 0;
    for (int i = 0; i < FL; i++) m_bits[i] = 0;
  endtask

  // Outcome of one clock edge given the beat presented on it
  task automatic model_step(input bit v, input bit fs, input bit d);
    bit x;
    m_fv = 0; m_se = 0; m_pe = 0;
    if (!v) return;
    if (fs) begin
      if (m_run && m_slot != 0) m_se = 1;
      m_run = 1; m_bits[0] = d; m_slot = 1;
    end else if (!m_run) begin
      // hunting: discard
    end else if (m_slot == 0) begin
      m_se = 1; m_run = 0;
    end else begin
      m_bits[m_slot] = d;
      if (m_slot == FL - 1) begin
        m_slot = 0;
        x = 0;
        for (int i = 0; i < FL; i++) x ^= m_bits[i];
        if (FL == N || x == 0) begin
          for (int i = 0; i < N; i++) m_y[i] = m_bits[i];
          m_fv = 1;
        end else m_pe = 1;
      end else m_slot++;
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".y"},    32'(y),           32'(m_y));
    chk({tag, ".fv"},   32'(frame_valid), 32'(m_fv));
    chk({tag, ".se"},   32'(sync_err),    32'(m_se));
    chk({tag, ".slot"}, 32'(slot),        32'(m_slot));
    chk({tag, ".excl"}, 32'(frame_valid & sync_err), 32'd0);
`ifdef DEMUX_PARITY_EN
    chk({tag, ".pe"},   32'(par_err),     32'(m_pe));
`endif
  endtask

  task automatic beat(input bit v, input bit fs, input bit d, input string tag);
    din_valid = v; frame_start = fs; din = d;
    model_step(v, fs, d);
    @(posedge clk); #1;
    cyc++;
    check_outs(tag);
    if (frame_valid) fv_cyc.push_back(cyc);
    if (sync_err) se_seen++;
  endtask

  // One frame starting at slot `from`; parity beat uses `par`
  task automatic send_frame(input logic [7:0] b, input int gap, input bit par, input int from, input string tag);
    bit d;
    for (int k = from; k < FL; k++) begin
      d = (k < N) ? b[k] : par;
      beat(1'b1, k == 0, d, tag);
      if (k < FL - 1)
        for (int g = 0; g < gap; g++) beat(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tag);
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset");
    @(negedge clk) rst_n = 1'b1;

    // clean frame
    fv_cyc.delete();
    send_frame(8'h4D, 0, ^8'h4D, 0, "clean");
    beat(1'b0, 1'b0, 1'b0, "clean");
    chk("clean_y", 32'(y), 32'h4D);
    chk("clean_fv_count", 32'(fv_cyc.size()), 32'd1);

    // gapped frame
    fv_cyc.delete();
    send_frame(8'h4D, 3, ^8'h4D, 0, "gap");
    repeat (4) beat(1'b0, 1'b0, 1'b0, "gap");
    chk("gap_y", 32'(y), 32'h4D);
    chk("gap_fv_count", 32'(fv_cyc.size()), 32'd1);

    // back-to-back frames
    fv_cyc.delete();
    send_frame(8'hA5, 0, ^8'hA5, 0, "b2b");
    chk("b2b_y0", 32'(y), 32'hA5);
    send_frame(8'h3C, 0, ^8'h3C, 0, "b2b");
    chk("b2b_y1", 32'(y), 32'h3C);
    chk("b2b_count", 32'(fv_cyc.size()), 32'd2);
    if (fv_cyc.size() == 2) chk("b2b_spacing", 32'(fv_cyc[1] - fv_cyc[0]), 32'(FL));

    // early restart at slot 5
    send_frame(8'hA5, 0, ^8'hA5, 0, "rs_pre");
    for (int k = 0; k < 5; k++) beat(1'b1, k == 0, 1'b0, "rs_part");
    se_seen = 0;
    beat(1'b1, 1'b1, 1'b1, "rs_hit");
    chk("rs_err", 32'(sync_err), 32'd1);
    chk("rs_hold", 32'(y), 32'hA5);
    send_frame(8'hFF, 0, ^8'hFF, 1, "rs_post");
    chk("rs_y", 32'(y), 32'hFF);
    chk("rs_err_count", 32'(se_seen), 32'd1);

    // missing frame_start at slot 0 in RUN
    beat(1'b1, 1'b0, 1'b1, "miss");
    chk("miss_err", 32'(sync_err), 32'd1);
    for (int k = 0; k < 10; k++) beat(1'b1, 1'b0, 1'($urandom_range(0, 1)), "hunt");
    chk("hunt_slot", 32'(slot), 32'd0);
    send_frame(8'h5A, 1, ^8'h5A, 0, "resync");
    chk("resync_y", 32'(y), 32'h5A);

    // async reset at slot 3
    for (int k = 0; k < 3; k++) beat(1'b1, k == 0, 1'b1, "rst_part");
    #2 rst_n = 1'b0;
    #1;
    chk("arst_y", 32'(y), 32'd0);
    chk("arst_slot", 32'(slot), 32'd0);
    model_reset();
    din_valid = 1'b0; frame_start = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    send_frame(8'hC3, 0, ^8'hC3, 0, "post_rst");
    chk("post_rst_y", 32'(y), 32'hC3);

`ifdef DEMUX_PARITY_EN
    send_frame(8'h01, 0, 1'b1, 0, "par_ok");
    chk("par_ok_y", 32'(y), 32'h01);
    send_frame(8'h80, 0, 1'b1, 0, "par_set");
    send_frame(8'h01, 0, 1'b0, 0, "par_bad");
    chk("par_bad_pe", 32'(par_err), 32'd1);
    chk("par_bad_y", 32'(y), 32'h80);
`endif

    // random streams, mostly well framed with occasional violations
    for (int i = 0; i < 3000; i++) begin
      bit v, fs, d;
      v  = ($urandom_range(0, 3) != 0);
      fs = (m_slot == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 29) == 0);
      d  = 1'($urandom_range(0, 1));
      beat(v, fs, d, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tdm_demux_1to8.md
Name: tdm_demux_1to8

Overview:
- Time-division demultiplexer: the receive-side counterpart of the team's 8:1 gate-level mux.
- A serial stream arrives one bit per valid beat, framed in 8-slot frames (slot 0 marked by frame_start).
- Each bit is steered to the lane matching its slot in a shadow register. The full 8-lane word is published on y with a one-cycle frame_valid strobe.
- Sits at the far end of a serialised link, restoring i0..i7-style parallel lanes.

Parameters:
- NUM_CH, 8, lanes per frame; power of two, 2..16; slot counter width = clog2(NUM_CH).
- DATA_W, 1, bits per lane per beat.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  DATA_W  serial data beat.
- din_valid  in  1  din is valid this cycle; beat accepted when high (no backpressure).
- frame_start  in  1  qualifies the current valid beat as slot 0; ignored when din_valid=0.
- y  out  NUM_CH*DATA_W  published lanes; lane k at bits [k*DATA_W +: DATA_W].
- frame_valid  out  1  one-cycle pulse: y updated this cycle.
- slot  out  clog2(NUM_CH)  slot the next accepted beat will occupy.
- sync_err  out  1  one-cycle pulse on framing violation.

Behaviour:
- Reset (async assert, sync release): y=0, frame_valid=0, slot=0, sync_err=0, shadow=0, state=IDLE.
- States: IDLE (hunting for frame_start) and RUN (in frame).
- IDLE:
  - Beats without frame_start are discarded silently; no error.
  - Valid beat with frame_start: shadow[0]<=din, slot<=1, go RUN.
- RUN, valid beat with slot!=0 and no frame_start: shadow[slot]<=din, slot<=slot+1.
- RUN, valid beat at slot==NUM_CH-1:
  - Next cycle: y <= shadow with lane NUM_CH-1 = din, frame_valid=1, slot=0.
  - State stays RUN. Latency = 1 cycle from the last beat to y/frame_valid.
- RUN, slot==0, valid beat with frame_start: normal new frame; shadow[0]<=din, slot<=1.
- RUN, slot==0, valid beat without frame_start: sync_err pulses next cycle, beat discarded, go IDLE, slot=0.
- RUN, slot!=0, valid beat with frame_start (early restart):
  - sync_err pulses next cycle; the partial frame is dropped (y unchanged).
  - The beat is taken as slot 0: shadow[0]<=din, slot<=1, stay RUN.
- din_valid=0: all state held; gaps of any length inside a frame are legal.
- A frame_valid and the slot-0 beat of the next frame may occur back-to-back; zero-bubble streaming required.
- y holds its value between frames. Only frame_valid updates y. Shadow content never leaks to y on error.
- Reset mid-frame: partial frame discarded, y cleared.
- frame_valid and sync_err are never high in the same cycle.

Optional Feature:
- Macro: DEMUX_PARITY_EN.
- Defined:
  - Frame is NUM_CH+1 beats; the extra beat (slot NUM_CH) carries even parity, the XOR of all lane bits including the parity beat = 0.
  - slot width grows to hold NUM_CH.
  - On the parity beat: if parity is correct, y/frame_valid update as above. If not, y is unchanged and output par_err pulses for one cycle.
  - Port par_err exists only when the macro is defined; reset value 0.
- Undefined: NUM_CH-beat frames; no parity beat; no par_err port.

Decomposition:
- Package tdm_demux_pkg holds:
  - state enum {ST_IDLE, ST_RUN};
  - default NUM_CH/DATA_W constants;
  - FRAME_LEN constant, NUM_CH or NUM_CH+1 under DEMUX_PARITY_EN.
- Sub-module tdm_slot_counter: modulo-FRAME_LEN counter with enable, sync load-to-1, clear, and wrap flag; one instance.
- The steering decode (slot -> lane write-enable) stays inline.

Test Plan:
- Clean frame: frame_start + bits 1,0,1,1,0,0,1,0 on consecutive cycles -> one cycle after last beat y=8'b0100_1101 (lane0=LSB), frame_valid=1 for 1 cycle, sync_err=0.
- Gapped frame: same bits with din_valid low 3 cycles between each beat -> identical y; frame_valid exactly once; slot holds during gaps.
- Back-to-back: frames 8'hA5 then 8'h3C with no idle cycle -> frame_valid on two cycles exactly 8 apart; y=8'hA5 then 8'h3C.
- Early restart: frame_start at slot 5 -> sync_err pulse; y keeps previous 8'hA5; following 8 beats 8'hFF -> y=8'hFF.
- Missing frame_start at slot 0 in RUN -> sync_err, IDLE, beats ignored until the next frame_start; rst_n low at slot 3 -> y=0, slot=0 immediately (async).
- DEMUX_PARITY_EN: frame 8'h01 + parity 1 -> frame_valid, y=8'h01; frame 8'h01 + parity 0 -> par_err pulse, y unchanged.
